sgd_weight_update: RTL and testbench

- Optimizer stage directly downstream of the convolution-backward FPU op. It consumes the weight-gradient tensor that op accumulates and applies a fixed-point SGD step in place on the weight tensor: W[k] ← sat32(W[k] − ((G[k]·lr) >>> FRAC_BITS)).
- It uses the same go/done operation handshake and mem_handle memory ports as the other FPU ops, so the operation dispatcher can sequence it immediately after the backward op.

---
 rtl/sgd_weight_update.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sgd_weight_update.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_weight_update.sv
// Fixed-point SGD optimizer step: W[k] <= sat32(W[k] - ((G[k]*lr) >>> FRAC_BITS)),
// applied in place on the weight tensor through two mem_handle ports (w, g).
module sgd_weight_update #(
    parameter int FRAC_BITS = 16,
    parameter int HDR_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_l,
    // weight tensor handle
    input  logic [31:0]        w_region_begin,
    input  logic               w_done,
    input  logic [31:0]        w_data_load,
    output logic [31:0]        w_ptr,
    output logic               w_r_en,
    output logic               w_w_en,
    output logic               w_avail,
    output logic               w_read_through,
    output logic               w_write_through,
    output logic [31:0]        w_data_store,
    // gradient tensor handle
    input  logic [31:0]        g_region_begin,
    input  logic               g_done,
    input  logic [31:0]        g_data_load,
    output logic [31:0]        g_ptr,
    output logic               g_r_en,
    output logic               g_w_en,
    output logic               g_avail,
    output logic               g_read_through,
    output logic               g_write_through,
    output logic [31:0]        g_data_store,
    // operation control
    input  logic [31:0]        lr,
    input  logic               go,
    output logic               done,
    output logic               err,
    output logic [31:0][31:0]  r
);

    typedef enum logic [2:0] {
        S_WAIT, S_START, S_HDR, S_SIZE, S_LOAD, S_CALC, S_STORE, S_DONE
    } state_t;

    localparam logic signed [64:0] SAT_MAX = 65'sd2147483647;
    localparam logic signed [64:0] SAT_MIN = -65'sd2147483648;

    state_t             state;
    logic               busy;
    logic               w_got;
    logic               g_got;
    logic [1:0]         beat;
    logic signed [31:0] w_word;
    logic signed [31:0] g_word;
    logic signed [31:0] lr_q;

    logic               w_hit;
    logic               g_hit;
    logic               pair_done;
    logic [31:0]        w_val;
    logic [31:0]        g_val;
    logic [31:0]        n_elem;
    logic signed [63:0] prod;
    logic signed [63:0] shifted;
    logic signed [64:0] diff;
    logic signed [31:0] upd;

    function automatic logic signed [31:0] sat32(input logic signed [64:0] v);
        if (v > SAT_MAX)
            return 32'sh7FFF_FFFF;
        else if (v < SAT_MIN)
            return 32'sh8000_0000;
        else
            return v[31:0];
    endfunction

    // The gradient handle is read-only.
    assign g_w_en          = 1'b0;
    assign g_write_through = 1'b0;
    assign g_data_store    = '0;

    // A word counts as arrived either from its latch or from this cycle's done.
    assign w_hit     = w_r_en & w_done;
    assign g_hit     = g_r_en & g_done;
    assign pair_done = busy & (w_got | w_hit) & (g_got | g_hit);
    assign w_val     = w_got ? w_word : w_data_load;
    assign g_val     = g_got ? g_word : g_data_load;
    assign n_elem    = r[2] * r[3] * r[4];

    always_comb begin
        prod    = 64'(g_word) * 64'(lr_q);
        shifted = prod >>> FRAC_BITS;
        diff    = 65'(w_word) - 65'(shifted);
        upd     = sat32(diff);
    end

    // Datapath capture: operands and learning rate, no reset needed.
    always_ff @(posedge clk) begin
        if (state == S_WAIT && go)
            lr_q <= lr;
        if (w_hit)
            w_word <= w_data_load;
        if (g_hit)
            g_word <= g_data_load;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= S_WAIT;
            busy            <= 1'b0;
            w_got           <= 1'b0;
            g_got           <= 1'b0;
            beat            <= 2'd0;
            done            <= 1'b0;
            err             <= 1'b0;
            r               <= '0;
            w_ptr           <= '0;
            w_r_en          <= 1'b0;
            w_w_en          <= 1'b0;
            w_avail         <= 1'b0;
            w_read_through  <= 1'b0;
            w_write_through <= 1'b0;
            w_data_store    <= '0;
            g_ptr           <= '0;
            g_r_en          <= 1'b0;
            g_avail         <= 1'b0;
            g_read_through  <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (go) begin
                        err   <= 1'b0;
                        state <= S_START;
                    end
                end

                S_START: begin
                    w_ptr <= w_region_begin + 32'd1;
                    g_ptr <= g_region_begin + 32'd1;
                    beat  <= 2'd0;
                    busy  <= 1'b0;
                    state <= S_HDR;
                end

                S_HDR: begin
                    if (!busy) begin
                        w_r_en  <= 1'b1;
                        w_avail <= 1'b1;
                        g_r_en  <= 1'b1;
                        g_avail <= 1'b1;
                        w_got   <= 1'b0;
                        g_got   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        if (w_hit) begin
                            w_r_en  <= 1'b0;
                            w_avail <= 1'b0;
                            w_got   <= 1'b1;
                        end
                        if (g_hit) begin
                            g_r_en  <= 1'b0;
                            g_avail <= 1'b0;
                            g_got   <= 1'b1;
                        end
                        if (pair_done) begin
                            busy                 <= 1'b0;
                            r[5'(beat) + 5'd2]   <= w_val;
                            if (g_val != w_val)
                                err <= 1'b1;
                            w_ptr <= w_ptr + 32'd1;
                            g_ptr <= g_ptr + 32'd1;
                            beat  <= beat + 2'd1;
                            if (beat == 2'd2)
                                state <= S_SIZE;
                        end
                    end
                end

                S_SIZE: begin
                    r[0]  <= n_elem;
                    r[1]  <= '0;
                    w_ptr <= w_region_begin + 32'(HDR_WORDS);
                    g_ptr <= g_region_begin + 32'(HDR_WORDS);
                    if (err || n_elem == 32'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (!busy) begin
                        w_r_en         <= 1'b1;
                        w_avail        <= 1'b1;
                        w_read_through <= 1'b1;
                        g_r_en         <= 1'b1;
                        g_avail        <= 1'b1;
                        w_got          <= 1'b0;
                        g_got          <= 1'b0;
                        busy           <= 1'b1;
                    end else begin
                        if (w_hit) begin
                            w_r_en         <= 1'b0;
                            w_avail        <= 1'b0;
                            w_read_through <= 1'b0;
                            w_got          <= 1'b1;
                        end
                        if (g_hit) begin
                            g_r_en  <= 1'b0;
                            g_avail <= 1'b0;
                            g_got   <= 1'b1;
                        end
                        if (pair_done) begin
                            busy  <= 1'b0;
                            state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    w_data_store <= upd;
                    state        <= S_STORE;
                end

                S_STORE: begin
                    if (!busy) begin
                        w_w_en          <= 1'b1;
                        w_avail         <= 1'b1;
                        w_write_through <= 1'b1;
                        busy            <= 1'b1;
                    end else if (w_w_en && w_done) begin
                        w_w_en          <= 1'b0;
                        w_avail         <= 1'b0;
                        w_write_through <= 1'b0;
                        busy            <= 1'b0;
                        w_ptr           <= w_ptr + 32'd1;
                        g_ptr           <= g_ptr + 32'd1;
                        r[1]            <= r[1] + 32'd1;
                        if (r[1] + 32'd1 == r[0]) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end

                S_DONE: begin
                    if (!go) begin
                        done  <= 1'b0;
                        state <= S_WAIT;
                    end
                end

                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgd_weight_update.sv
// Bench for sgd_weight_update: memory responders with random done delays and a
// plain-arithmetic model of the saturating SGD step.
module tb_sgd_weight_update;

    localparam int WB = 16;
    localparam int GB = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l;
    logic [31:0] w_region_begin, g_region_begin;
    logic        w_done = 1'b0, g_done = 1'b0;
    logic [31:0] w_data_load = '0, g_data_load = '0;
    logic [31:0] w_ptr, g_ptr, w_data_store, g_data_store;
    logic        w_r_en, w_w_en, w_avail, w_read_through, w_write_through;
    logic        g_r_en, g_w_en, g_avail, g_read_through, g_write_through;
    logic [31:0] lr;
    logic        go;
    logic        done, err;
    logic [31:0][31:0] r;

    sgd_weight_update #(.FRAC_BITS(16), .HDR_WORDS(4)) dut (
        .clk(clk), .rst_l(rst_l),
        .w_region_begin(w_region_begin), .w_done(w_done), .w_data_load(w_data_load),
        .w_ptr(w_ptr), .w_r_en(w_r_en), .w_w_en(w_w_en), .w_avail(w_avail),
        .w_read_through(w_read_through), .w_write_through(w_write_through),
        .w_data_store(w_data_store),
        .g_region_begin(g_region_begin), .g_done(g_done), .g_data_load(g_data_load),
        .g_ptr(g_ptr), .g_r_en(g_r_en), .g_w_en(g_w_en), .g_avail(g_avail),
        .g_read_through(g_read_through), .g_write_through(g_write_through),
        .g_data_store(g_data_store),
        .lr(lr), .go(go), .done(done), .err(err), .r(r)
    );

    logic [31:0] wmem [256];
    logic [31:0] gmem [256];
    logic [31:0] wimg [256];
    logic [31:0] gimg [256];
    logic [31:0] exp_w [64];
    logic [31:0] snap [64];
    int load_seq = 0;
    int dly_max = 0;
    int w_last_seq = 0, g_last_seq = 0;
    int w_cnt = 0, g_cnt = 0;
    bit w_busy = 1'b0, g_busy = 1'b0;
    int w_reads = 0, w_writes = 0, g_reads = 0;
    int g_wen_seen = 0;
    int n_pass = 0, n_total = 0;

    // Weight memory: random response delay, done valid for one cycle.
    always @(negedge clk) begin
        if (load_seq != w_last_seq) begin
            w_last_seq = load_seq;
            for (int i = 0; i < 256; i++) wmem[i] = wimg[i];
        end
        if (w_done) begin
            w_done = 1'b0;
            w_busy = 1'b0;
        end else if (!(w_r_en || w_w_en)) begin
            w_busy = 1'b0;
        end else begin
            if (!w_busy) begin
                w_busy = 1'b1;
                w_cnt  = int'($urandom_range(dly_max, 0));
            end else if (w_cnt > 0) begin
                w_cnt--;
            end
            if (w_cnt == 0) begin
                w_done = 1'b1;
                if (w_r_en) begin
                    w_data_load = wmem[w_ptr[7:0]];
                    w_reads++;
                end
                if (w_w_en) begin
                    wmem[w_ptr[7:0]] = w_data_store;
                    w_writes++;
                end
            end
        end
    end

    // Gradient memory: read-only responder.
    always @(negedge clk) begin
        if (load_seq != g_last_seq) begin
            g_last_seq = load_seq;
            for (int i = 0; i < 256; i++) gmem[i] = gimg[i];
        end
        if (g_done) begin
            g_done = 1'b0;
            g_busy = 1'b0;
        end else if (!g_r_en) begin
            g_busy = 1'b0;
        end else begin
            if (!g_busy) begin
                g_busy = 1'b1;
                g_cnt  = int'($urandom_range(dly_max, 0));
            end else if (g_cnt > 0) begin
                g_cnt--;
            end
            if (g_cnt == 0) begin
                g_done = 1'b1;
                g_data_load = gmem[g_ptr[7:0]];
                g_reads++;
            end
        end
    end

    always @(posedge clk) if (g_w_en) g_wen_seen++;

    function automatic logic [31:0] model_step(input logic [31:0] wv, input logic [31:0] gv,
                                               input logic [31:0] lv);
        longint p, s, t;
        p = longint'($signed(gv)) * longint'($signed(lv));
        s = p >>> 16;
        t = longint'($signed(wv)) - s;
        if (t > 64'sd2147483647) t = 64'sd2147483647;
        if (t < -64'sd2147483648) t = -64'sd2147483648;
        return t[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic build(input int d1, input int d2, input int d3,
                         input int e1, input int e2, input int e3);
        wimg[WB] = 32'd3; wimg[WB+1] = d1; wimg[WB+2] = d2; wimg[WB+3] = d3;
        gimg[GB] = 32'd3; gimg[GB+1] = e1; gimg[GB+2] = e2; gimg[GB+3] = e3;
        load_seq++;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(output int cyc);
        go  = 1'b1;
        cyc = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) break;
        end
        if (!done) chk("timeout", 32'(done), 32'd1);
    endtask

    task automatic end_op();
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_elems(input string tag, input int n);
        for (int k = 0; k < n; k++) chk(tag, wmem[WB+4+k], exp_w[k]);
    endtask

    task automatic rand_tensor(input int n);
        for (int k = 0; k < n; k++) begin
            wimg[WB+4+k] = $urandom;
            gimg[GB+4+k] = $urandom;
        end
    endtask

    initial begin
        int cyc, base_w, base_r, base_gr, diffs;
        logic [31:0] lrv;
        rst_l = 1'b0; go = 1'b0; lr = '0;
        w_region_begin = WB; g_region_begin = GB;
        for (int i = 0; i < 256; i++) begin wimg[i] = '0; gimg[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_r0", r[0], 32'd0);
        chk("rst_en", 32'({w_r_en, w_w_en, w_avail, g_r_en, g_avail}), 32'd0);
        chk("rst_ptr", w_ptr, 32'd0);
        rst_l = 1'b1;
        @(negedge clk);

        // Basic step, single-cycle memory
        wimg[WB+4] = 32'h0001_0000; wimg[WB+5] = 32'h0002_0000;
        wimg[WB+6] = 32'hFFFF_0000; wimg[WB+7] = 32'h0000_0000;
        gimg[GB+4] = 32'h0001_0000; gimg[GB+5] = 32'h0002_0000;
        gimg[GB+6] = 32'h0001_0000; gimg[GB+7] = 32'hFFFC_0000;
        exp_w[0] = 32'h0000_8000; exp_w[1] = 32'h0001_0000;
        exp_w[2] = 32'hFFFE_8000; exp_w[3] = 32'h0002_0000;
        build(1, 2, 2, 1, 2, 2);
        base_w = w_writes;
        lr = 32'h0000_8000;
        run_op(cyc);
        chk("basic_latency", cyc, 32'd29);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_err", 32'(err), 32'd0);
        chk("basic_r0", r[0], 32'd4);
        chk("basic_r1", r[1], 32'd4);
        chk("basic_dims", {r[2][7:0], r[3][7:0], r[4][7:0], 8'd0}, 32'h0102_0200);
        chk("basic_writes", w_writes - base_w, 32'd4);
        chk_elems("basic_elem", 4);
        end_op();

        // Saturation at both rails
        wimg[WB+4] = 32'h7FFF_FFF0; wimg[WB+5] = 32'h8000_0010;
        gimg[GB+4] = 32'hFFF0_0000; gimg[GB+5] = 32'h0010_0000;
        exp_w[0] = 32'h7FFF_FFFF; exp_w[1] = 32'h8000_0000;
        build(1, 1, 2, 1, 1, 2);
        lr = 32'h0001_0000;
        run_op(cyc);
        chk("sat_err", 32'(err), 32'd0);
        chk_elems("sat_elem", 2);
        end_op();

        // Shape mismatch leaves w untouched
        rand_tensor(24);
        build(2, 3, 4, 2, 4, 3);
        for (int k = 0; k < 24; k++) snap[k] = wmem[WB+4+k];
        base_w = w_writes;
        lr = $urandom;
        run_op(cyc);
        chk("mm_done", 32'(done), 32'd1);
        chk("mm_err", 32'(err), 32'd1);
        chk("mm_writes", w_writes - base_w, 32'd0);
        diffs = 0;
        for (int k = 0; k < 24; k++) if (wmem[WB+4+k] !== snap[k]) diffs++;
        chk("mm_unchanged", diffs, 32'd0);
        end_op();

        // Empty tensor: header reads only, err cleared from previous op
        build(1, 0, 5, 1, 0, 5);
        base_r = w_reads; base_gr = g_reads; base_w = w_writes;
        run_op(cyc);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_err", 32'(err), 32'd0);
        chk("empty_r0", r[0], 32'd0);
        chk("empty_wreads", w_reads - base_r, 32'd3);
        chk("empty_greads", g_reads - base_gr, 32'd3);
        chk("empty_writes", w_writes - base_w, 32'd0);
        end_op();

        // Random done delays, random data, N=27
        dly_max = 5;
        rand_tensor(27);
        build(3, 3, 3, 3, 3, 3);
        lrv = $urandom_range(32'h0004_0000, 0);
        if ($urandom_range(1, 0) == 1) lrv = -lrv;
        lr = lrv;
        for (int k = 0; k < 27; k++) exp_w[k] = model_step(wimg[WB+4+k], gimg[GB+4+k], lrv);
        base_w = w_writes;
        run_op(cyc);
        chk("rnd_done", 32'(done), 32'd1);
        chk("rnd_r0", r[0], 32'd27);
        chk("rnd_writes", w_writes - base_w, 32'd27);
        chk_elems("rnd_elem", 27);
        end_op();

        // Reset after five element writes, then restart from partial memory
        dly_max = 3;
        rand_tensor(27);
        build(3, 3, 3, 3, 3, 3);
        lrv = $urandom;
        lr = lrv;
        base_w = w_writes;
        go = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #2;
            if (w_writes - base_w >= 5) break;
        end
        chk("rstmid_reached", 32'(w_writes - base_w >= 5), 32'd1);
        rst_l = 1'b0;
        #1;
        chk("rstmid_en", 32'({w_r_en, w_w_en, w_avail, w_read_through, w_write_through,
                              g_r_en, g_avail, g_read_through}), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        go = 1'b0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 27; k++) exp_w[k] = model_step(wmem[WB+4+k], gmem[GB+4+k], lrv);
        run_op(cyc);
        chk("restart_done", 32'(done), 32'd1);
        chk("restart_r1", r[1], 32'd27);
        chk_elems("restart_elem", 27);
        end_op();

        chk("g_never_written", g_wen_seen, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
